// File: rtl/seven_seg_capture.sv
// Recovers a two-digit number from a multiplexed seven-segment bus.
// Filters each digit pattern for stability, decodes it and publishes complete frames.
module seven_seg_capture #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic [6:0] seg,
   input  logic [1:0] sel,
   input  logic       err_clr,
   output logic [3:0] ones,
   output logic [3:0] tens,
   output logic [6:0] value,
   output logic       valid,
   output logic       err
);

   localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      EMPTY,
      HAVE_ONES,
      HAVE_TENS
   } state_t;

   state_t     state;
   state_t     state_nxt;
   logic [8:0] key;
   logic [8:0] prev_key;
   logic [3:0] cnt;
   logic [3:0] cnt_nxt;
   logic       same;
   logic       hit;
   logic       onehot;
   logic       cap;
   logic       dec_ok;
   logic [3:0] dec_dig;
   logic       cap_ok;
   logic       cap_bad;
   logic       cap_ones;
   logic       cap_tens;
   logic [3:0] ones_nxt;
   logic [3:0] tens_nxt;
   logic [6:0] sum;
   logic       complete;

   assign key  = {sel, seg};
   assign same = (key == prev_key);

   always_comb begin
      cnt_nxt = 4'd1;
      if (same)
         cnt_nxt = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
   end

   // Fire only on the edge the run first reaches the threshold, even when saturated.
   assign hit    = (cnt_nxt == STABLE) && !(same && (cnt == STABLE));
   assign onehot = (sel == 2'b01) || (sel == 2'b10);
   assign cap    = hit && onehot;

   always_comb begin
      dec_ok  = 1'b1;
      dec_dig = 4'd0;
      case (seg)
         7'h7E: dec_dig = 4'd0;
         7'h30: dec_dig = 4'd1;
         7'h6D: dec_dig = 4'd2;
         7'h79: dec_dig = 4'd3;
         7'h33: dec_dig = 4'd4;
         7'h5B: dec_dig = 4'd5;
         7'h5F: dec_dig = 4'd6;
         7'h70: dec_dig = 4'd7;
         7'h7F: dec_dig = 4'd8;
         7'h7B: dec_dig = 4'd9;
         default: dec_ok = 1'b0;
      endcase
   end

   assign cap_ok   = cap && dec_ok;
   assign cap_bad  = cap && !dec_ok;
   assign cap_ones = cap_ok && sel[0];
   assign cap_tens = cap_ok && sel[1];
   assign ones_nxt = cap_ones ? dec_dig : ones;
   assign tens_nxt = cap_tens ? dec_dig : tens;
   assign sum      = {tens_nxt, 3'b000} + 7'({tens_nxt, 1'b0}) + 7'(ones_nxt);

   always_comb begin
      state_nxt = state;
      complete  = 1'b0;
      unique case (state)
         EMPTY: begin
            if (cap_ones)
               state_nxt = HAVE_ONES;
            else if (cap_tens)
               state_nxt = HAVE_TENS;
         end
         HAVE_ONES: begin
            if (cap_tens) begin
               complete  = 1'b1;
               state_nxt = EMPTY;
            end
         end
         HAVE_TENS: begin
            if (cap_ones) begin
               complete  = 1'b1;
               state_nxt = EMPTY;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         state <= EMPTY;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         prev_key <= '0;
         cnt      <= '0;
         ones     <= '0;
         tens     <= '0;
         value    <= '0;
         valid    <= 1'b0;
         err      <= 1'b0;
      end else begin
         prev_key <= key;
         cnt      <= cnt_nxt;
         ones     <= ones_nxt;
         tens     <= tens_nxt;
         valid    <= complete;
         if (complete)
            value <= sum;
         if (cap_bad)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture.
// Each scenario task drives the bus and checks outputs one step after the edge.
module tb_seven_seg_capture;

   logic       clk;
   logic       resetn;
   logic [6:0] seg;
   logic [1:0] sel;
   logic       err_clr;
   logic [3:0] ones;
   logic [3:0] tens;
   logic [6:0] value;
   logic       valid;
   logic       err;

   int checks;
   int errors;
   int vcnt;

   seven_seg_capture #(.STABLE_CYCLES(4)) dut (
      .clk     (clk),
      .resetn  (resetn),
      .seg     (seg),
      .sel     (sel),
      .err_clr (err_clr),
      .ones    (ones),
      .tens    (tens),
      .value   (value),
      .valid   (valid),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input logic [6:0] sg, input logic [1:0] sl);
      seg = sg;
      sel = sl;
      @(posedge clk);
      #1;
      if (valid === 1'b1)
         vcnt++;
   endtask

   task automatic ticks(input logic [6:0] sg, input logic [1:0] sl, input int n);
      for (int i = 0; i < n; i++)
         tick(sg, sl);
   endtask

   task automatic test_reset;
      resetn  = 1'b0;
      err_clr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         seg = 7'($urandom);
         sel = 2'($urandom);
         @(posedge clk);
         #1;
      end
      checks++;
      if ({ones, tens, value, valid, err} !== 17'd0) begin
         errors++;
         $display("FAIL reset_hold got %h want 0", {ones, tens, value, valid, err});
      end
      resetn = 1'b1;
      vcnt   = 0;
      ticks(7'h00, 2'b00, 10);
      checks++;
      if ({ones, tens, value, valid, err} !== 17'd0 || vcnt != 0) begin
         errors++;
         $display("FAIL reset_idle got %h vcnt %0d want 0", {ones, tens, value, valid, err}, vcnt);
      end
   endtask

   task automatic test_frame;
      vcnt = 0;
      ticks(7'h70, 2'b01, 3);
      checks++;
      if (ones !== 4'd0) begin
         errors++;
         $display("FAIL frame_early got ones %0d want 0", ones);
      end
      tick(7'h70, 2'b01);
      checks++;
      if (ones !== 4'd7 || valid !== 1'b0) begin
         errors++;
         $display("FAIL frame_ones got %0d/%b want 7/0", ones, valid);
      end
      ticks(7'h33, 2'b10, 3);
      checks++;
      if (valid !== 1'b0 || tens !== 4'd0) begin
         errors++;
         $display("FAIL frame_tens_early got %0d/%b want 0/0", tens, valid);
      end
      tick(7'h33, 2'b10);
      checks++;
      if (tens !== 4'd4 || value !== 7'd47 || valid !== 1'b1) begin
         errors++;
         $display("FAIL frame_done got %0d/%0d/%b want 4/47/1", tens, value, valid);
      end
      tick(7'h33, 2'b10);
      checks++;
      if (valid !== 1'b0 || value !== 7'd47 || vcnt != 1) begin
         errors++;
         $display("FAIL frame_strobe got %b/%0d/%0d want 0/47/1", valid, value, vcnt);
      end
   endtask

   task automatic test_glitch_hold;
      vcnt = 0;
      ticks(7'h6D, 2'b10, 3);
      checks++;
      if (tens !== 4'd4 || value !== 7'd47 || err !== 1'b0) begin
         errors++;
         $display("FAIL glitch got %0d/%0d/%b want 4/47/0", tens, value, err);
      end
      ticks(7'h7B, 2'b01, 20);
      checks++;
      if (ones !== 4'd9 || vcnt != 0 || value !== 7'd47) begin
         errors++;
         $display("FAIL hold got %0d/%0d/%0d want 9/0/47", ones, vcnt, value);
      end
   endtask

   task automatic test_error;
      ticks(7'h00, 2'b01, 4);
      checks++;
      if (err !== 1'b1 || ones !== 4'd9) begin
         errors++;
         $display("FAIL err_set got %b/%0d want 1/9", err, ones);
      end
      err_clr = 1'b1;
      tick(7'h00, 2'b01);
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clr got %b want 0", err);
      end
      ticks(7'h00, 2'b10, 3);
      err_clr = 1'b1;
      tick(7'h00, 2'b10);
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b1 || tens !== 4'd4) begin
         errors++;
         $display("FAIL err_set_wins got %b/%0d want 1/4", err, tens);
      end
      err_clr = 1'b1;
      tick(7'h00, 2'b10);
      err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clr2 got %b want 0", err);
      end
   endtask

   task automatic test_illegal_sel;
      vcnt = 0;
      ticks(7'h7E, 2'b11, 8);
      checks++;
      if (ones !== 4'd9 || tens !== 4'd4 || vcnt != 0) begin
         errors++;
         $display("FAIL sel11 got %0d/%0d/%0d want 9/4/0", ones, tens, vcnt);
      end
      ticks(7'h5F, 2'b01, 4);
      checks++;
      if (ones !== 4'd6 || vcnt != 0) begin
         errors++;
         $display("FAIL ones_overwrite got %0d/%0d want 6/0", ones, vcnt);
      end
      ticks(7'h30, 2'b10, 4);
      checks++;
      if (value !== 7'd16 || valid !== 1'b1 || tens !== 4'd1) begin
         errors++;
         $display("FAIL frame16 got %0d/%b/%0d want 16/1/1", value, valid, tens);
      end
   endtask

   task automatic test_reset_mid;
      ticks(7'h79, 2'b01, 4);
      checks++;
      if (ones !== 4'd3) begin
         errors++;
         $display("FAIL mid_ones got %0d want 3", ones);
      end
      resetn = 1'b0;
      #2;
      checks++;
      if (ones !== 4'd0 || value !== 7'd0) begin
         errors++;
         $display("FAIL mid_reset got %0d/%0d want 0/0", ones, value);
      end
      resetn = 1'b1;
      vcnt   = 0;
      ticks(7'h6D, 2'b10, 6);
      checks++;
      if (tens !== 4'd2 || vcnt != 0 || value !== 7'd0) begin
         errors++;
         $display("FAIL tens_alone got %0d/%0d/%0d want 2/0/0", tens, vcnt, value);
      end
      ticks(7'h7F, 2'b01, 4);
      checks++;
      if (value !== 7'd28 || valid !== 1'b1 || ones !== 4'd8) begin
         errors++;
         $display("FAIL frame28 got %0d/%b/%0d want 28/1/8", value, valid, ones);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      vcnt    = 0;
      resetn  = 1'b0;
      seg     = '0;
      sel     = '0;
      err_clr = 1'b0;
      test_reset();
      test_frame();
      test_glitch_hold();
      test_error();
      test_illegal_sel();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
